// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch predictor:
// BTB entry layout, counter init values, PC index/tag extraction.
package bpu_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_jump;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    function automatic int ctr_wnt(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int ctr_wt(int w);
        return 1 << (w - 1);
    endfunction

    function automatic logic [31:0] pc_idx(logic [31:0] pc, int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(logic [31:0] pc, int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// Next-value logic for a CTR_W-bit saturating up/down counter.
module bpu_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = ctr;
        if (inc) begin
            if (ctr != '1) nxt = ctr + CTR_W'(1);
        end else if (ctr != '0) begin
            nxt = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// BHT + BTB branch predictor with EX-stage resolution and training.
// Optional event counters enabled by defining BPU_STATS_EN.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [31:0]     if_pred_target,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    input  logic            ex_valid,
    output logic [31:0]     pc_four,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            j_sel
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_ctl,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));

    btb_entry_t       btb [DEPTH];
    logic [CTR_W-1:0] ctr [DEPTH];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [31:0]      if_tag, ex_tag, ex_pc32;
    logic             if_hit, ex_hit, ctl, taken;
    logic [31:0]      act_target, act_next;
    logic [CTR_W-1:0] ctr_nxt;

    assign if_idx = IDX_W'(pc_idx(32'(if_pc), IDX_W));
    assign if_tag = pc_tag(32'(if_pc), IDX_W);
    assign ex_idx = IDX_W'(pc_idx(32'(ex_pc), IDX_W));
    assign ex_tag = pc_tag(32'(ex_pc), IDX_W);

    assign if_hit = btb[if_idx].valid && (btb[if_idx].tag == if_tag);
    assign if_pred_taken = if_hit
                        && (btb[if_idx].is_jump || ctr[if_idx][CTR_W-1]);
    assign if_pred_target = if_pred_taken ? btb[if_idx].target : '0;

    assign ex_pc32 = 32'(ex_pc);
    assign pc_four = ex_pc32 + 32'd4;
    assign ctl     = ex_branch | ex_jal | ex_jalr;
    assign j_sel   = ex_jal | ex_jalr;
    assign taken   = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);

    assign act_target = ex_jalr ? (ex_alu_result & ~32'h1)
                                : ex_pc32 + ex_imm;
    assign act_next   = taken ? act_target : pc_four;

    // A stale alias on a non-control op falls out here: taken=0 vs pred=1
    assign redirect = ex_valid
                   && ((ex_pred_taken != taken)
                   || (taken && (ex_pred_target != act_target)));
    assign redirect_pc = redirect ? act_next : '0;

    assign ex_hit = btb[ex_idx].valid && (btb[ex_idx].tag == ex_tag);

    bpu_sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .ctr (ctr[ex_idx]),
        .inc (taken),
        .nxt (ctr_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i].valid <= 1'b0;
                ctr[i]       <= WNT;
            end
        end else if (ex_valid) begin
            if (ex_branch) begin
                if (ex_hit) ctr[ex_idx] <= ctr_nxt;
                else        ctr[ex_idx] <= taken ? WT : WNT;
            end
            if (ctl && taken) begin
                btb[ex_idx].valid   <= 1'b1;
                btb[ex_idx].is_jump <= j_sel;
                btb[ex_idx].tag     <= ex_tag;
                btb[ex_idx].target  <= act_target;
            end else if (!ctl && ex_hit) begin
                btb[ex_idx].valid <= 1'b0;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ctl     <= '0;
            stat_mispred <= '0;
        end else begin
            if (ex_valid && ctl && stat_ctl != '1)
                stat_ctl <= stat_ctl + 32'd1;
            if (redirect && stat_mispred != '1)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch resolver.
- Adds a direct-mapped branch history table (BHT) of saturating counters and a branch target buffer (BTB), both indexed by PC.
- The IF stage queries the tables for a next-PC prediction. The EX stage resolves branches and jumps, flags mispredictions with a redirect target, and trains the tables on the clock edge.

Parameters:
- PC_W, 9, PC width in bits. PC_W >= IDX_W+3 is required.
- IDX_W, 4, table index width. Depth is 2**IDX_W entries.
- CTR_W, 2, saturating counter width. CTR_W >= 2 is required.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  fetch PC.
- if_pred_taken  out  1  predicted taken.
- if_pred_target  out  32  predicted target (valid when if_pred_taken=1).
- ex_pc  in  PC_W  PC of the instruction in EX.
- ex_imm  in  32  immediate.
- ex_branch  in  1  conditional branch in EX.
- ex_jal  in  1  JAL in EX.
- ex_jalr  in  1  JALR in EX.
- ex_alu_result  in  32  ALU result. Bit0 is the branch condition; the full word is the JALR target.
- ex_pred_taken  in  1  prediction carried down the pipe for this instruction.
- ex_pred_target  in  32  predicted target carried down the pipe.
- ex_valid  in  1  EX instruction is valid (not a bubble or flushed).
- pc_four  out  32  zero-extended ex_pc + 4 (link value).
- redirect  out  1  mispredict: flush IF/ID and load redirect_pc.
- redirect_pc  out  32  correct next PC.
- j_sel  out  1  ex_jal | ex_jalr (selects pc_four for writeback).

Behaviour:
- Reset (reset=0, asynchronous): every BHT counter goes to weakly-not-taken (value 2**(CTR_W-1)-1). All BTB valid bits clear. No other state.
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2].
- Prediction is combinational from the tables.
  - hit = valid[idx] && tag[idx] == if_tag.
  - if_pred_taken = hit && (is_jump[idx] || ctr[idx] MSB == 1).
  - if_pred_target = target[idx] when if_pred_taken, else 0.
- Resolution is combinational; ctl = ex_branch | ex_jal | ex_jalr.
  - taken = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]).
  - act_target = (ex_alu_result & ~32'h1) when JALR, else zero-extended ex_pc + ex_imm.
  - act_next = taken ? act_target : pc_four.
  - redirect = ex_valid & (ex_pred_taken != taken | (taken & ex_pred_target != act_target)).
  - A non-control instruction predicted taken (stale alias) also redirects, with act_next = pc_four.
  - redirect_pc = act_next when redirect, else 0.
  - All arithmetic is 32-bit modulo 2**32; wrap-around is silent.
- Training on the rising edge when ex_valid:
  - Conditional branch: counter increments on taken, decrements on not-taken, saturating at 0 and 2**CTR_W-1.
  - Taken control transfer: entry is written with valid=1, tag, target=act_target, is_jump=(jal|jalr).
  - Branch allocation: when a branch allocates a new entry (miss), the counter initialises to weakly-taken (2**(CTR_W-1)) if taken, weakly-not-taken if not taken.
  - Non-control instruction on a hit: entry is invalidated.
- Same-index read and write in one cycle: IF sees the pre-update value; there is no bypass.
- ex_valid=0: no training and redirect=0. pc_four and j_sel are still driven.
- Reset asserted mid-operation clears the tables immediately. The next prediction after release is not-taken.

Optional Feature:
- Macro: BPU_STATS_EN.
- Defined:
  - Adds outputs stat_ctl (32) and stat_mispred (32).
  - stat_ctl increments on each ex_valid&ctl cycle.
  - stat_mispred increments on each redirect cycle.
  - Both saturate at 2**32-1 and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package bpu_pkg holds:
  - CTR_WNT/CTR_WT reset and allocation constants.
  - typedef btb_entry_t {valid, is_jump, tag, target}.
  - Index and tag extraction functions.
- One sub-module, bpu_sat_counter: a combinational next-value function with CTR_W and saturation.
- Tables stay in the top module, as they need a reset loop.

Test Plan:
- After reset: if_pc=0x10 -> if_pred_taken=0. Branch at 0x10 with imm=0x20, alu[0]=1, pred 0 -> redirect=1, redirect_pc=0x30. Next cycle if_pc=0x10 predicts taken with target 0x30.
- Counter saturation: same branch taken 4 times, then not-taken once -> still predicts taken. A second not-taken -> predicts not-taken. No counter wrap.
- JALR at 0x40 with alu_result=0x1235 and pred_target=0x1234, pred 1 -> redirect=0, j_sel=1, pc_four=0x44.
- Aliasing: PCs 0x08 and 0x48 (IDX_W=4, same index, different tag). Train 0x08 taken, then query 0x48 -> no hit, pred 0.
- ex_valid=0 with a mispredicted branch -> redirect=0 and tables unchanged. Assert reset mid-run -> all predictions 0 on the next cycle.
- BPU_STATS_EN: 5 control instructions including 2 mispredicts -> stat_ctl=5, stat_mispred=2.
